// File: rtl/right_shift_deserializer_ctrl_if.sv
// rtl/right_shift_deserializer_ctrl_if.sv - serial-in / word-out handshake bundle
//
// Purpose: groups the serial bit handshake and the word handoff handshake of
// the deserializer controller.
// Signals:
//   serial_in, serial_valid, serial_ready   serial bit handshake
//   word[DEPTH], word_valid, word_ready     assembled word handshake
//   parity_error                            parity flag, qualified by word_valid
// Modports:
//   slave  - controller side (accepts bits, produces words)
//   master - link/consumer side (offers bits, takes words)
interface right_shift_deserializer_ctrl_if #(
  parameter int DEPTH = 8
);
  logic             serial_in;
  logic             serial_valid;
  logic             serial_ready;
  logic [DEPTH-1:0] word;
  logic             word_valid;
  logic             word_ready;
  logic             parity_error;

  modport slave (
    input  serial_in, serial_valid, word_ready,
    output serial_ready, word, word_valid, parity_error
  );

  modport master (
    output serial_in, serial_valid, word_ready,
    input  serial_ready, word, word_valid, parity_error
  );
endinterface

// File: rtl/right_shift_deserializer_ctrl.sv
// rtl/right_shift_deserializer_ctrl.sv - sequences an external right shift register as a deserializer
//
// Purpose: accepts DEPTH serial bits, shifting each into an external right
// shift register, then offers the register contents as one word until taken.
// First accepted bit lands in word[0], last in word[DEPTH-1].
// Optional feature macro: PARITY_CHECK_EN - one extra even-parity bit per
// frame, checked against the data bits and reported on parity_error.
// Ports:
//   clk_i           clock, rising edge
//   reset_i         synchronous active-high reset (also zeroes frame count)
//   clear_i         synchronous frame abort
//   bus             serial/word handshake bundle (slave modport)
//   sr_in_o         shift register data input
//   sr_enable_o     shift register shift enable
//   sr_reset_o      shift register synchronous reset
//   sr_out_i        shift register parallel contents
//   frame_count_o   count of words handed off, wrapping
module right_shift_deserializer_ctrl #(
  parameter int DEPTH       = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          clear_i,
  right_shift_deserializer_ctrl_if.slave bus,
  output logic                          sr_in_o,
  output logic                          sr_enable_o,
  output logic                          sr_reset_o,
  input  logic [DEPTH-1:0]              sr_out_i,
  output logic [COUNT_WIDTH-1:0]        frame_count_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_SHIFT  = 2'd0,
    S_PARITY = 2'd1,
    S_FULL   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [COUNT_WIDTH-1:0]  frame_count_q, frame_count_d;
  logic                    serial_ready;
  logic                    accept;
`ifdef PARITY_CHECK_EN
  logic                    par_acc_q, par_acc_d;
  logic                    perr_q, perr_d;
`endif

  // Ready is withdrawn combinationally during clear/reset so a bit offered
  // in an aborting cycle is never counted as taken.
  assign serial_ready = ((state_q == S_SHIFT) || (state_q == S_PARITY)) && !clear_i && !reset_i;
  assign accept       = bus.serial_valid & serial_ready;

  assign bus.serial_ready = serial_ready;
  assign bus.word_valid   = (state_q == S_FULL);
  assign bus.word         = sr_out_i;
`ifdef PARITY_CHECK_EN
  assign bus.parity_error = (state_q == S_FULL) & perr_q;
`else
  assign bus.parity_error = 1'b0;
`endif

  assign sr_in_o       = bus.serial_in;
  // The parity bit is accepted but never shifted into the register.
  assign sr_enable_o   = accept & (state_q == S_SHIFT);
  assign sr_reset_o    = reset_i | clear_i;
  assign frame_count_o = frame_count_q;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    frame_count_d = frame_count_q;
`ifdef PARITY_CHECK_EN
    par_acc_d     = par_acc_q;
    perr_d        = perr_q;
`endif
    if (clear_i) begin
      state_d   = S_SHIFT;
      bit_cnt_d = '0;
`ifdef PARITY_CHECK_EN
      par_acc_d = 1'b0;
      perr_d    = 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_SHIFT: begin
          if (accept) begin
`ifdef PARITY_CHECK_EN
            par_acc_d = par_acc_q ^ bus.serial_in;
`endif
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = '0;
`ifdef PARITY_CHECK_EN
              state_d   = S_PARITY;
`else
              state_d   = S_FULL;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
        end
        S_PARITY: begin
`ifdef PARITY_CHECK_EN
          if (accept) begin
            perr_d    = par_acc_q ^ bus.serial_in;
            par_acc_d = 1'b0;
            state_d   = S_FULL;
          end
`else
          state_d = S_SHIFT;
`endif
        end
        S_FULL: begin
          // Handoff cycle deliberately refuses new bits (ready is low in FULL).
          if (bus.word_ready) begin
            frame_count_d = frame_count_q + COUNT_WIDTH'(1);
            state_d       = S_SHIFT;
          end
        end
        default: state_d = S_SHIFT;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= S_SHIFT;
      bit_cnt_q     <= '0;
      frame_count_q <= '0;
`ifdef PARITY_CHECK_EN
      par_acc_q     <= 1'b0;
      perr_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_count_q <= frame_count_d;
`ifdef PARITY_CHECK_EN
      par_acc_q     <= par_acc_d;
      perr_q        <= perr_d;
`endif
    end
  end

endmodule
